go_delay_chain: RTL and testbench
=================================

// Module: go_delay_chain
// PURPOSE
//  Parametrised chain of NUM_STAGES go->delay->done stages with per-stage programmable delay,
//  per-stage cascade enable and per-stage sticky kill latches.
//  Each stage raises a one-cycle done pulse D+2 cycles after go unless it is killed first.
//  Sits between sequencing/control logic and downstream actuators; done_out marks chain completion.
// PARAMETERS
//  NUM_STAGES  3   number of delay stages (>=1)
//  DELAY_W     8   width of each stage delay field / down-counter
// PORTS
//  clk         in   1                    system clock, all logic on rising edge
//  reset_n     in   1                    synchronous reset, active-low
//  go_in       in   NUM_STAGES           external go per stage
//  kill_in     in   NUM_STAGES           abort per stage
//  kill_clr    in   NUM_STAGES           clear per-stage kill latch
//  casc_en     in   NUM_STAGES           bit i (i>0): done[i-1] also triggers stage i; bit 0 ignored
//  delay_cfg   in   NUM_STAGES*DELAY_W   stage i delay D_i at [i*DELAY_W +: DELAY_W]
//  busy        out  NUM_STAGES           stage i in BUSY
//  done        out  NUM_STAGES           one-cycle completion pulse per stage
//  done_out    out  1                    = done[NUM_STAGES-1]
//  kill_ltchd  out  NUM_STAGES           sticky kill flags
//  kill_any    out  1                    OR of kill_ltchd
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): all states IDLE, counters 0; busy, done, done_out, kill_ltchd, kill_any = 0.
//    Reset mid-count aborts without a done pulse.
//  - Effective go: g[0]=go_in[0]; g[i]=go_in[i] | (casc_en[i] & done[i-1]).
//  - Effective kill: k[i]=kill_in[i] (see CONFIGURATION).
//  - Per-stage FSM, all outputs registered:
//    IDLE: k -> IDLE. Else g -> BUSY with cnt<=D_i; D_i is sampled only here.
//    BUSY: k -> IDLE. Else cnt==0 -> DONE. Else cnt<=cnt-1.
//    DONE: done=1 for this cycle only. Next state is IDLE, or IDLE if k.
//      A new go in the DONE cycle is ignored.
//  - Latency: go high in cycle c, with no kill -> done high in cycle c+D+2 (D=0 -> c+2).
//    Cascade adds the same per stage: stage i starts in the cycle after done[i-1].
//  - go while BUSY or DONE: ignored, no retrigger, delay not reloaded.
//  - kill has priority over go in the same cycle. The done pulse already registered in DONE is not retracted.
//  - Kill latch i: set on kill_in[i]; cleared on kill_clr[i]; set wins when both are high.
//    Updates on the edge after the input; kill_any is registered with it.
//  - Counter is unsigned DELAY_W bits, decrement only, never wraps (stops at 0).
// CONFIGURATION
//  GO_DELAY_KILL_CHAIN_EN defined:
//    k[i] = kill_in[i] | (casc_en[i] & k[i-1]), combinational.
//    A kill aborts every downstream cascaded stage in the same cycle.
//    kill_ltchd still records only kill_in.
//  Not defined: k[i] = kill_in[i]; a kill affects only its own stage.
// STRUCTURE
//  - Package go_delay_pkg: state encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10 (typedef go_dly_state_t).
//  - Sub-module go_delay_stage (clk, reset_n, go, kill, delay, busy, done), one FSM plus counter,
//    instantiated NUM_STAGES times in a generate loop.
//  - Cascade/kill-chain wiring, kill latches and kill_any live in the top level.
// TESTING
//  1. NUM_STAGES=3, D0=3, go_in[0] pulse cycle 10, casc_en=0 -> done[0] only in cycle 15; busy[0] cycles 11-14.
//  2. casc_en=3'b110, D={2,1,0}, go_in[0] cycle 10 -> done[0]@12, done[1]@15, done[2]/done_out@19.
//  3. Stage 0 D=5 started cycle 10, kill_in[0] cycle 13 -> IDLE cycle 14, no done[0];
//     kill_ltchd[0]=kill_any=1 from cycle 14. kill_clr[0] with kill_in[0] -> stays 1; kill_clr alone -> 0 next cycle.
//  4. go_in[0] re-pulsed cycles 12 and 13 during a D=4 count from cycle 10 -> single done[0]@16, no reload.
//  5. reset_n=0 cycle 13 mid-count -> all outputs 0 from cycle 14; no done; kill_ltchd cleared.
//  6. GO_DELAY_KILL_CHAIN_EN, casc_en=3'b110, all stages BUSY, kill_in[0] -> all three IDLE next cycle;
//     only kill_ltchd[0] set. Same stimulus without the macro -> stages 1 and 2 complete normally.

Source files
------------

// File: rtl/go_delay_pkg.sv
// Shared types for the go->delay->done chain: per-stage FSM state encoding
// and default sizing.
package go_delay_pkg;

  localparam int unsigned DEF_NUM_STAGES = 3;
  localparam int unsigned DEF_DELAY_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } go_dly_state_t;

endpackage

// File: rtl/go_delay_chain_if.sv
// Control/status bundle of the go delay chain.
//   master: drives go_in, kill_in, kill_clr, casc_en, delay_cfg;
//           observes busy, done, done_out, kill_ltchd, kill_any
//   slave : the chain itself (mirror directions)
interface go_delay_chain_if #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned DELAY_W    = 8
);

  localparam int unsigned CFG_W = NUM_STAGES * DELAY_W;

  logic [NUM_STAGES-1:0] go_in;
  logic [NUM_STAGES-1:0] kill_in;
  logic [NUM_STAGES-1:0] kill_clr;
  logic [NUM_STAGES-1:0] casc_en;
  logic [CFG_W-1:0]      delay_cfg;
  logic [NUM_STAGES-1:0] busy;
  logic [NUM_STAGES-1:0] done;
  logic                  done_out;
  logic [NUM_STAGES-1:0] kill_ltchd;
  logic                  kill_any;

  modport master (
    output go_in, kill_in, kill_clr, casc_en, delay_cfg,
    input  busy, done, done_out, kill_ltchd, kill_any
  );

  modport slave (
    input  go_in, kill_in, kill_clr, casc_en, delay_cfg,
    output busy, done, done_out, kill_ltchd, kill_any
  );

endinterface

// File: rtl/go_delay_stage.sv
// One go->delay->done stage: FSM plus down-counter.
// A go in IDLE loads the delay; the done pulse appears delay+2 cycles after go.
//   clk, reset_n : clock, synchronous active-low reset
//   go, kill     : start request, abort (kill wins)
//   delay        : delay value, sampled only when leaving IDLE
//   busy, done   : registered status, done is a one-cycle pulse
module go_delay_stage
  import go_delay_pkg::*;
#(
  parameter int unsigned DELAY_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               go,
  input  logic               kill,
  input  logic [DELAY_W-1:0] delay,
  output logic               busy,
  output logic               done
);

  go_dly_state_t      state_q, state_n;
  logic [DELAY_W-1:0] cnt_q, cnt_n;

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      busy    <= (state_n == BUSY);
      done    <= (state_n == DONE);
    end
  end

  // Next-state and counter update
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!kill && go) begin
          state_n = BUSY;
          cnt_n   = delay;
        end
      end
      BUSY: begin
        if (kill) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt_q - DELAY_W'(1);
        end
      end
      DONE: begin
        // Single-cycle pulse; a go arriving here is dropped.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/go_delay_chain.sv
// Chain of NUM_STAGES go->delay->done stages with cascade enable, sticky
// per-stage kill latches and a chain-completion flag.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : go_in, kill_in, kill_clr, casc_en, delay_cfg in;
//                  busy, done, done_out, kill_ltchd, kill_any out
// Optional feature macro: GO_DELAY_KILL_CHAIN_EN -- a kill propagates
// combinationally into every downstream cascaded stage.
module go_delay_chain
  import go_delay_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned DELAY_W    = DEF_DELAY_W
) (
  input  logic          clk,
  input  logic          reset_n,
  go_delay_chain_if.slave bus
);

  logic [NUM_STAGES-1:0] go_eff;
  logic [NUM_STAGES-1:0] kill_eff;
  logic [NUM_STAGES-1:0] busy_w;
  logic [NUM_STAGES-1:0] done_w;
  logic [NUM_STAGES-1:0] kill_ltchd_q, kill_ltchd_n;
  logic                  kill_any_q;
  logic                  casc_unused;

  // Stage 0 has no upstream, so its cascade bit has no meaning.
  assign casc_unused = bus.casc_en[0];

  // Effective go: external go or upstream done when cascaded
  always_comb begin
    go_eff = bus.go_in;
    for (int i = 1; i < int'(NUM_STAGES); i++) begin
      go_eff[i] = bus.go_in[i] | (bus.casc_en[i] & done_w[i-1]);
    end
  end

`ifdef GO_DELAY_KILL_CHAIN_EN
  // Kill ripples down through cascaded stages in the same cycle
  always_comb begin
    kill_eff = bus.kill_in;
    for (int i = 1; i < int'(NUM_STAGES); i++) begin
      kill_eff[i] = bus.kill_in[i] | (bus.casc_en[i] & kill_eff[i-1]);
    end
  end
`else
  // Kill affects only its own stage
  always_comb begin
    kill_eff = bus.kill_in;
  end
`endif

  for (genvar g = 0; g < int'(NUM_STAGES); g++) begin : g_stage
    go_delay_stage #(
      .DELAY_W (DELAY_W)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (go_eff[g]),
      .kill    (kill_eff[g]),
      .delay   (bus.delay_cfg[g*DELAY_W +: DELAY_W]),
      .busy    (busy_w[g]),
      .done    (done_w[g])
    );
  end

  // Sticky kill latches: set dominates clear; only external kills are recorded
  always_comb begin
    kill_ltchd_n = (kill_ltchd_q & ~bus.kill_clr) | bus.kill_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kill_ltchd_q <= '0;
      kill_any_q   <= 1'b0;
    end else begin
      kill_ltchd_q <= kill_ltchd_n;
      kill_any_q   <= |kill_ltchd_n;
    end
  end

  assign bus.busy       = busy_w;
  assign bus.done       = done_w;
  assign bus.done_out   = done_w[NUM_STAGES-1];
  assign bus.kill_ltchd = kill_ltchd_q;
  assign bus.kill_any   = kill_any_q;

endmodule

// File: tb/tb_go_delay_chain.sv
// Directed bench for go_delay_chain. Offsets j count cycles after the cycle
// in which the stimulus was applied; outputs are sampled 1 time unit after
// each rising edge, inputs are then set for that same cycle.
module tb_go_delay_chain;
  import go_delay_pkg::*;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;
`ifdef GO_DELAY_KILL_CHAIN_EN
  localparam bit KCHAIN = 1'b1;
`else
  localparam bit KCHAIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  go_delay_chain_if #(.NUM_STAGES(N), .DELAY_W(W)) bus ();

  go_delay_chain #(.NUM_STAGES(N), .DELAY_W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int j, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s j=%0d observed=%0h expected=%0h", tag, j, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.go_in    = '0;
    bus.kill_in  = '0;
    bus.kill_clr = '0;
    bus.casc_en  = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [N-1:0] eb, ed;

  initial begin
    reset_n       = 1'b0;
    bus.delay_cfg = '0;
    clear_inputs();
    tick(); tick(); tick();

    // Reset state
    chk("rst_busy", 0, 32'(bus.busy), 32'h0);
    chk("rst_done", 0, 32'(bus.done), 32'h0);
    chk("rst_done_out", 0, 32'(bus.done_out), 32'h0);
    chk("rst_kill_ltchd", 0, 32'(bus.kill_ltchd), 32'h0);
    chk("rst_kill_any", 0, 32'(bus.kill_any), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // 1: single stage, D0=3, no cascade -> busy j1..4, done j5
    bus.delay_cfg = {8'd0, 8'd0, 8'd3};
    bus.go_in = 3'b001;
    for (int j = 1; j <= 7; j++) begin
      tick();
      bus.go_in = '0;
      eb = (j >= 1 && j <= 4) ? 3'b001 : 3'b000;
      ed = (j == 5) ? 3'b001 : 3'b000;
      chk("t1_busy", j, 32'(bus.busy), 32'(eb));
      chk("t1_done", j, 32'(bus.done), 32'(ed));
    end
    idle(2);

    // 2: cascade, D0=0 D1=1 D2=2 -> done0 j2, done1 j5, done2 j9
    bus.delay_cfg = {8'd2, 8'd1, 8'd0};
    bus.casc_en = 3'b110;
    bus.go_in = 3'b001;
    for (int j = 1; j <= 10; j++) begin
      tick();
      bus.go_in = '0;
      eb = {(j >= 6 && j <= 8), (j >= 3 && j <= 4), (j == 1)};
      ed = {(j == 9), (j == 5), (j == 2)};
      chk("t2_busy", j, 32'(bus.busy), 32'(eb));
      chk("t2_done", j, 32'(bus.done), 32'(ed));
      chk("t2_done_out", j, 32'(bus.done_out), 32'(j == 9));
    end
    idle(2);

    // 3: kill mid-count, then latch set/clear behaviour
    bus.delay_cfg = {8'd0, 8'd0, 8'd5};
    bus.go_in = 3'b001;
    for (int j = 1; j <= 8; j++) begin
      tick();
      bus.go_in    = '0;
      bus.kill_in  = '0;
      bus.kill_clr = '0;
      chk("t3_busy", j, 32'(bus.busy), 32'((j <= 3) ? 3'b001 : 3'b000));
      chk("t3_done", j, 32'(bus.done), 32'h0);
      chk("t3_kill_ltchd", j, 32'(bus.kill_ltchd), 32'((j >= 4 && j <= 5) ? 3'b001 : 3'b000));
      chk("t3_kill_any", j, 32'(bus.kill_any), 32'(j >= 4 && j <= 5));
      if (j == 3) bus.kill_in = 3'b001;
      if (j == 4) begin bus.kill_in = 3'b001; bus.kill_clr = 3'b001; end
      if (j == 5) bus.kill_clr = 3'b001;
    end
    idle(2);

    // 4: go re-pulsed while busy, D0=4 -> one done at j6, no reload
    bus.delay_cfg = {8'd0, 8'd0, 8'd4};
    bus.go_in = 3'b001;
    for (int j = 1; j <= 9; j++) begin
      tick();
      bus.go_in = (j == 2 || j == 3) ? 3'b001 : 3'b000;
      chk("t4_busy", j, 32'(bus.busy), 32'((j <= 5) ? 3'b001 : 3'b000));
      chk("t4_done", j, 32'(bus.done), 32'((j == 6) ? 3'b001 : 3'b000));
    end
    idle(2);

    // 5: reset mid-count also clears a set kill latch
    bus.delay_cfg = {8'd0, 8'd0, 8'd5};
    bus.go_in   = 3'b001;
    bus.kill_in = 3'b010;
    for (int j = 1; j <= 9; j++) begin
      tick();
      bus.go_in   = '0;
      bus.kill_in = '0;
      reset_n = (j == 3) ? 1'b0 : 1'b1;
      chk("t5_busy", j, 32'(bus.busy), 32'((j <= 3) ? 3'b001 : 3'b000));
      chk("t5_done", j, 32'(bus.done), 32'h0);
      chk("t5_kill_ltchd", j, 32'(bus.kill_ltchd), 32'((j <= 3) ? 3'b010 : 3'b000));
      chk("t5_kill_any", j, 32'(bus.kill_any), 32'(j <= 3));
    end
    reset_n = 1'b1;
    idle(2);

    // 6: all stages busy, kill stage 0; chained kill depends on build
    bus.delay_cfg = {8'd5, 8'd5, 8'd5};
    bus.casc_en = 3'b110;
    bus.go_in   = 3'b111;
    for (int j = 1; j <= 9; j++) begin
      tick();
      bus.go_in   = '0;
      bus.kill_in = (j == 2) ? 3'b001 : 3'b000;
      if (j <= 2)      eb = 3'b111;
      else if (KCHAIN) eb = 3'b000;
      else             eb = (j <= 6) ? 3'b110 : 3'b000;
      ed = (!KCHAIN && j == 7) ? 3'b110 : 3'b000;
      chk("t6_busy", j, 32'(bus.busy), 32'(eb));
      chk("t6_done", j, 32'(bus.done), 32'(ed));
      chk("t6_done_out", j, 32'(bus.done_out), 32'(ed[2]));
      chk("t6_kill_ltchd", j, 32'(bus.kill_ltchd), 32'((j >= 3) ? 3'b001 : 3'b000));
    end
    bus.kill_clr = 3'b001;
    tick();
    bus.kill_clr = '0;
    tick();
    chk("t6_clr", 0, 32'(bus.kill_ltchd), 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
